systolic_job_sched: RTL and testbench
=====================================

# systolic_job_sched

Job scheduler that shares one N×N systolic matrix-multiply core between two requesters. It arbitrates round-robin between two request ports and latches the winning job's operand matrices. It then sequences the core: skewed operand feed, drain, accumulator sync and result capture. The result is returned to the owning port with a valid/ready handshake. It sits between the host-side job sources and the `systolic` core instance.

## Interface
- W, 32, element width in bits
- N, 3, array dimension
- P_DRAIN, 3*N, cycles of zero feed after the last operand step; must be ≥ 2N-2
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high; clock i_clk
- i_en  in  1  global run enable; low freezes the block
- i_reqK_valid / o_reqK_ready (K=0,1)  in/out  1  job request handshake
- i_reqK_A, i_reqK_B  in  W*N*N  operands; word e = bits [(e+1)W-1:eW]
- i_reqK_mode  in  1  mode bit passed to the core
- o_sys_en, o_sys_sync, o_sys_mode  out  1  core controls
- o_sys_A, o_sys_B  out  W*N  skewed lane buses; lane j = bits [(j+1)W-1:jW]
- i_sys_C  in  W*N*N  core result
- o_rsp_valid  out  1  result available
- i_rsp_ready  in  1  consumer accepts result
- o_rsp_id  out  1  port that owns the result
- o_rsp_C  out  W*N*N  captured result

## Operation
- FSM states: IDLE → FEED → DRAIN → CAPTURE → RESP → IDLE.
- **IDLE:** o_reqK_ready=1 only for the granted port; at most one ready is high at a time.
  - Grant rule: if exactly one port is valid, grant it.
  - If both are valid, grant the port not served last.
  - The last-served pointer resets to 1, so port 0 wins the first tie.
- **Accept** (valid & ready at an edge):
  - latch A, B and mode;
  - set the owner id;
  - update the last-served pointer;
  - enter FEED with step counter k=0.
- **FEED, N cycles, k=0..N-1:**
  - The raw step word for A lane j is A word k*N+j; same for B.
  - Lane j passes through a j-stage skew delay before o_sys_A / o_sys_B.
  - Lane 0 is undelayed.
- **DRAIN, P_DRAIN cycles:** raw step words are zero; the skew lines flush.
- **CAPTURE, 1 cycle:**
  - o_sys_sync=1; o_sys_en=1.
  - o_rsp_C <= i_sys_C at the end of the cycle.
- **RESP:**
  - o_rsp_valid=1 with o_rsp_C and o_rsp_id stable.
  - Leave on valid & i_rsp_ready; no new job is accepted in the same cycle.
- o_sys_en = i_en while in FEED, DRAIN or CAPTURE; otherwise 0.
- o_sys_mode = latched mode.
- **i_en=0 stall:**
  - The FSM, step and drain counters, skew lines and arbiter pointer hold.
  - All ready outputs are 0.
  - RESP handshake still completes, because the consumer side is not stalled.
- Request operands are ignored unless accepted; they need not be held after accept.

## Timing
- Reset values:
  - all outputs 0; state IDLE; counters 0; skew lines 0; pointer 1.
  - o_rsp_C = 0; o_rsp_id = 0.
- Accept edge = cycle 0. FEED spans cycles 1..N; DRAIN spans N+1..N+P_DRAIN; CAPTURE is N+P_DRAIN+1.
- o_rsp_valid rises in cycle N+P_DRAIN+2 with no stalls; this is 14 for the defaults.
- Each i_en=0 cycle adds one cycle of latency.
- Skew: raw word (step k, lane j) appears on the lane-j output in cycle 1+k+j. Outside those cycles, lanes carry 0.
- Earliest next accept: the cycle after the RESP handshake edge. Zero-bubble back-to-back is not supported.
- Reset mid-operation:
  - aborts the job; no response is issued;
  - skew lines are cleared;
  - o_sys_sync is not pulsed, because the core is reset by the same i_rst.
- A request valid dropping in IDLE before accept is legal; arbitration re-evaluates every cycle.

## Structure
- Shared package `systolic_pkg`:
  - FSM state enum (IDLE, FEED, DRAIN, CAPTURE, RESP);
  - default W/N constants;
  - the word-index helper function e = k*N+j.
- Sub-module `skew_line`:
  - parameterised WIDTH and DEPTH (DEPTH 0 = wire);
  - stall input; synchronous zero reset.
  - Instantiated 2(N-1) times, for lanes 1..N-1 of A and B.
- Arbiter logic stays inline, since it is two requesters with one pointer.

## Test plan
- Single job on port 0 (A = identity, B = words 1..9), real core attached:
  - o_rsp_valid in cycle 14; o_rsp_C = B; o_rsp_id=0;
  - o_sys_sync is high exactly in cycle 13.
- Both ports valid from reset:
  - port 0 is served first, then port 1;
  - a third simultaneous request goes to port 0 again, confirming alternation;
  - ready is never high on both ports at once.
- Skew check on a port-1 job with A words 10..18:
  - o_sys_A lane 2 shows 12, 15, 18 in cycles 3, 4, 5;
  - lane 2 is 0 in cycles 1, 2 and 6.
- Hold i_rsp_ready=0 for 5 cycles after valid: o_rsp_valid, o_rsp_C and o_rsp_id stay stable; no new accept occurs.
- Drop i_en for 4 cycles mid-FEED:
  - the lane outputs and state freeze;
  - o_rsp_valid arrives in cycle 18; result unchanged.
- Assert i_rst in cycle 5 of a job:
  - the next cycle shows all outputs 0 and state IDLE;
  - no response is issued;
  - a new job then completes normally in 14 cycles.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic job scheduler.
//   sched_state_t : scheduler FSM states
//   W_DEF, N_DEF  : default element width and array dimension
//   word_idx()    : flat operand word index for step k, lane j
package systolic_pkg;

    localparam int W_DEF = 32;
    localparam int N_DEF = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FEED    = 3'd1,
        DRAIN   = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } sched_state_t;

    // Word e of a packed N*N operand occupies bits [(e+1)W-1:eW].
    function automatic int word_idx(input int k, input int j, input int n);
        return k * n + j;
    endfunction

endpackage

// File: rtl/skew_line.sv
// Stallable delay line used to skew one operand lane into the array.
//   i_clk, i_rst : clock, synchronous active-high reset (clears every stage)
//   stall        : hold all stages when high
//   d, q         : WIDTH-bit lane in/out; q is d delayed by DEPTH cycles
//   DEPTH = 0 degenerates to a plain wire.
module skew_line #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             stall,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else if (!stall) begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_job_sched.sv
// Round-robin job scheduler sharing one N x N systolic core between two ports.
//   i_clk, i_rst             : clock, synchronous active-high reset
//   i_en                     : global run enable (low freezes sequencing)
//   i_reqK_*/o_reqK_ready    : job request handshake + operands/mode, K = 0,1
//   o_sys_en/sync/mode       : core controls
//   o_sys_A, o_sys_B         : skewed lane buses into the core
//   i_sys_C                  : core result, captured during CAPTURE
//   o_rsp_valid/i_rsp_ready  : result handshake; o_rsp_id = owning port
//   o_rsp_C                  : captured result
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | arbitrate; ready high only for the granted port
// FEED    | step k = 0..N-1, raw operand words enter the skew lines
// DRAIN   | P_DRAIN cycles of zero feed while the skew lines flush
// CAPTURE | pulse sync, latch i_sys_C into the response register
// RESP    | hold result valid until the consumer takes it
module systolic_job_sched
    import systolic_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int N       = N_DEF,
    parameter int P_DRAIN = 3 * N
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [W*N*N-1:0] i_req0_A,
    input  logic [W*N*N-1:0] i_req0_B,
    input  logic             i_req0_mode,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [W*N*N-1:0] i_req1_A,
    input  logic [W*N*N-1:0] i_req1_B,
    input  logic             i_req1_mode,
    output logic             o_sys_en,
    output logic             o_sys_sync,
    output logic             o_sys_mode,
    output logic [W*N-1:0]   o_sys_A,
    output logic [W*N-1:0]   o_sys_B,
    input  logic [W*N*N-1:0] i_sys_C,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_rsp_id,
    output logic [W*N*N-1:0] o_rsp_C
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = (P_DRAIN > 1) ? $clog2(P_DRAIN) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [DW-1:0] D_LOAD = DW'(P_DRAIN - 1);

    sched_state_t     state;
    logic [KW-1:0]    k;
    logic [DW-1:0]    drain_cnt;
    logic             last_srv;
    logic             owner;
    logic             mode_q;
    logic [W*N*N-1:0] a_q;
    logic [W*N*N-1:0] b_q;
    logic [W*N*N-1:0] rsp_c;
    logic             rsp_valid;

    logic gnt0, gnt1, can_accept, take0, take1;

    // Tie goes to the port that was not served last.
    assign gnt0 = i_req0_valid && (!i_req1_valid || last_srv);
    assign gnt1 = i_req1_valid && (!i_req0_valid || !last_srv);

    // Reset is folded in so ready reads 0 while reset is held.
    assign can_accept   = (state == IDLE) && i_en && !i_rst;
    assign o_req0_ready = can_accept && gnt0;
    assign o_req1_ready = can_accept && gnt1;
    assign take0        = i_req0_valid && o_req0_ready;
    assign take1        = i_req1_valid && o_req1_ready;

    assign o_sys_en    = i_en && ((state == FEED) || (state == DRAIN) || (state == CAPTURE));
    // A stalled CAPTURE captures nothing, so sync only asserts on the capturing cycle.
    assign o_sys_sync  = i_en && (state == CAPTURE);
    assign o_sys_mode  = mode_q;
    assign o_rsp_valid = rsp_valid;
    assign o_rsp_id    = owner;
    assign o_rsp_C     = rsp_c;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            k         <= '0;
            drain_cnt <= '0;
            last_srv  <= 1'b1;
            owner     <= 1'b0;
            mode_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_c     <= '0;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take0 || take1) begin
                        a_q      <= take1 ? i_req1_A : i_req0_A;
                        b_q      <= take1 ? i_req1_B : i_req0_B;
                        mode_q   <= take1 ? i_req1_mode : i_req0_mode;
                        owner    <= take1;
                        last_srv <= take1;
                        k        <= '0;
                        state    <= FEED;
                    end
                end
                FEED: begin
                    if (i_en) begin
                        if (k == K_LAST) begin
                            k         <= '0;
                            drain_cnt <= D_LOAD;
                            state     <= DRAIN;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (i_en) begin
                        if (drain_cnt == '0) state <= CAPTURE;
                        else                 drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    if (i_en) begin
                        rsp_c     <= i_sys_C;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    // Consumer side is never stalled by i_en.
                    if (i_rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_lane
        logic [W-1:0] raw_a, raw_b, skw_a, skw_b;

        always_comb begin
            raw_a = '0;
            raw_b = '0;
            if (state == FEED) begin
                raw_a = a_q[W*word_idx(int'(k), j, N) +: W];
                raw_b = b_q[W*word_idx(int'(k), j, N) +: W];
            end
        end

        if (j == 0) begin : g_direct
            assign skw_a = raw_a;
            assign skw_b = raw_b;
        end else begin : g_skew
            skew_line #(.WIDTH(W), .DEPTH(j)) u_skew_a (
                .i_clk (i_clk),
                .i_rst (i_rst),
                .stall (!i_en),
                .d     (raw_a),
                .q     (skw_a)
            );
            skew_line #(.WIDTH(W), .DEPTH(j)) u_skew_b (
                .i_clk (i_clk),
                .i_rst (i_rst),
                .stall (!i_en),
                .d     (raw_b),
                .q     (skw_b)
            );
        end

        assign o_sys_A[j*W +: W] = skw_a;
        assign o_sys_B[j*W +: W] = skw_b;
    end

endmodule

// File: tb/tb_systolic_job_sched.sv
// Scoreboard bench for systolic_job_sched with a behavioural reference model.
module tb_systolic_job_sched;

    localparam int W       = 32;
    localparam int N       = 3;
    localparam int P_DRAIN = 3 * N;
    localparam int NE      = N * N;
    localparam int MW      = W * NE;
    localparam int EFF_CAP = N + P_DRAIN + 1;
    localparam int EFF_RSP = N + P_DRAIN + 2;

    logic          clk = 1'b0;
    logic          rst, en;
    logic          v0, v1, r0, r1, m0, m1;
    logic [MW-1:0] a0, b0, a1, b1;
    logic          sys_en, sys_sync, sys_mode;
    logic [W*N-1:0] sys_a, sys_b;
    logic [MW-1:0] sys_c, noise;
    logic          rsp_valid, rsp_ready, rsp_id;
    logic [MW-1:0] rsp_c;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit            id;
        logic [MW-1:0] c;
    } exp_t;
    exp_t sb_q[$];

    // Reference model state: job in flight, enabled edges since accept.
    bit            m_busy = 1'b0;
    int            m_eff  = 0;
    bit            m_ptr  = 1'b1;
    bit            m_mode = 1'b0;
    bit            m_id   = 1'b0;
    logic [MW-1:0] m_a    = '0;
    logic [MW-1:0] m_b    = '0;
    logic [MW-1:0] m_prod = '0;
    logic [MW-1:0] m_rspc = '0;

    always #5 clk = ~clk;

    // Core stand-in: the true result is only visible during the sync cycle.
    assign sys_c = sys_sync ? m_prod : noise;

    systolic_job_sched #(.W(W), .N(N), .P_DRAIN(P_DRAIN)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_req0_valid (v0),
        .o_req0_ready (r0),
        .i_req0_A     (a0),
        .i_req0_B     (b0),
        .i_req0_mode  (m0),
        .i_req1_valid (v1),
        .o_req1_ready (r1),
        .i_req1_A     (a1),
        .i_req1_B     (b1),
        .i_req1_mode  (m1),
        .o_sys_en     (sys_en),
        .o_sys_sync   (sys_sync),
        .o_sys_mode   (sys_mode),
        .o_sys_A      (sys_a),
        .o_sys_B      (sys_b),
        .i_sys_C      (sys_c),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_id     (rsp_id),
        .o_rsp_C      (rsp_c)
    );

    task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // C word (i,j) = sum over steps k of A(k,i) * B(k,j), mod 2^W.
    function automatic logic [MW-1:0] ref_prod(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [MW-1:0] c;
        logic [W-1:0]  acc;
        c = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                acc = '0;
                for (int s = 0; s < N; s++)
                    acc = acc + a[(s*N+i)*W +: W] * b[(s*N+j)*W +: W];
                c[(i*N+j)*W +: W] = acc;
            end
        return c;
    endfunction

    // Word (step s, lane j) appears on lane j exactly at effective cycle 1+s+j.
    function automatic logic [W-1:0] exp_lane(input logic [MW-1:0] m, input int eff, input int j);
        int s;
        s = eff - 1 - j;
        if (s >= 0 && s < N) return m[(s*N+j)*W +: W];
        return '0;
    endfunction

    always @(negedge clk) begin : p_model
        bit g0, g1, e_r0, e_r1, w;
        g0   = v0 && (!v1 || m_ptr);
        g1   = v1 && (!v0 || !m_ptr);
        e_r0 = !m_busy && en && g0;
        e_r1 = !m_busy && en && g1;
        if (!rst) begin
            chk("req0_ready", r0, e_r0);
            chk("req1_ready", r1, e_r1);
            chk("ready_both", r0 && r1, 0);
            chk("rsp_valid", rsp_valid, m_busy && m_eff >= EFF_RSP);
            chk("sys_en", sys_en, en && m_busy && m_eff <= EFF_CAP);
            chk("sys_sync", sys_sync, en && m_busy && m_eff == EFF_CAP);
            chk("sys_mode", sys_mode, m_mode);
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_C", rsp_c, m_rspc);
            for (int j = 0; j < N; j++) begin
                chk($sformatf("lane_A%0d", j), sys_a[j*W +: W], m_busy ? exp_lane(m_a, m_eff, j) : '0);
                chk($sformatf("lane_B%0d", j), sys_b[j*W +: W], m_busy ? exp_lane(m_b, m_eff, j) : '0);
            end
        end
        for (int e = 0; e < NE; e++) noise[e*W +: W] = $urandom;
        if (rst) begin
            m_busy = 1'b0; m_eff = 0; m_ptr = 1'b1; m_mode = 1'b0;
            m_id = 1'b0; m_rspc = '0;
            sb_q.delete();
        end else if (!m_busy) begin
            if ((v0 && e_r0) || (v1 && e_r1)) begin
                w      = v1 && e_r1;
                m_a    = w ? a1 : a0;
                m_b    = w ? b1 : b0;
                m_mode = w ? m1 : m0;
                m_id   = w;
                m_ptr  = w;
                m_prod = ref_prod(m_a, m_b);
                m_busy = 1'b1;
                m_eff  = 1;
                sb_q.push_back('{id: w, c: m_prod});
            end
        end else if (m_eff < EFF_RSP) begin
            if (en) begin
                if (m_eff == EFF_CAP) m_rspc = m_prod;
                m_eff++;
            end
        end else if (rsp_ready) begin
            m_busy = 1'b0;
        end
    end

    always @(negedge clk) begin : p_mon
        exp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: got response id %0d expected none", rsp_id);
            end else begin
                e = sb_q.pop_front();
                chk("sb_C", rsp_c, e.c);
                chk("sb_id", rsp_id, e.id);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int e = 0; e < NE; e++) begin
            a0[e*W +: W] = $urandom;
            b0[e*W +: W] = $urandom;
            a1[e*W +: W] = $urandom;
            b1[e*W +: W] = $urandom;
        end
        m0 = 1'($urandom_range(0, 1));
        m1 = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_accept(output int port);
        bit ok;
        ok   = 1'b0;
        port = -1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (v0 && r0) begin ok = 1'b1; port = 0; end
            else if (v1 && r1) begin ok = 1'b1; port = 1; end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept, expected one within 200 cycles");
        end
        tick();
    endtask

    task automatic wait_resp(output int lat);
        bit ok;
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) ok = 1'b1;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp_timeout: got no response, expected one within 200 cycles");
        end
    endtask

    initial begin : p_drive
        int port, lat;
        int ord[3];
        logic [MW-1:0] b_ref;
        logic [W-1:0]  lane2_exp[6];
        ord = '{0, 1, 0};
        lane2_exp = '{32'd0, 32'd0, 32'd12, 32'd15, 32'd18, 32'd0};

        rst = 1'b1; en = 1'b1; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;
        rand_ops();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Both ports valid from reset: 0, 1, 0.
        v0 = 1'b1; v1 = 1'b1;
        for (int t = 0; t < 3; t++) begin
            wait_accept(port);
            chk("tie_order", port, ord[t]);
            if (t == 2) begin v0 = 1'b0; v1 = 1'b0; end
            rand_ops();
            wait_resp(lat);
            chk("tie_latency", lat, 14);
            tick();
        end

        // Identity A on port 0: result equals B.
        for (int e = 0; e < NE; e++) begin
            a0[e*W +: W] = (e % (N + 1) == 0) ? 32'd1 : 32'd0;
            b0[e*W +: W] = 32'(e + 1);
        end
        b_ref = b0;
        m0 = 1'b1; v0 = 1'b1;
        wait_accept(port);
        v0 = 1'b0;
        chk("ident_port", port, 0);
        wait_resp(lat);
        chk("ident_latency", lat, 14);
        chk("ident_C", rsp_c, b_ref);
        chk("ident_id", rsp_id, 0);
        tick();

        // Skew on a port-1 job with A words 10..18.
        rand_ops();
        for (int e = 0; e < NE; e++) a1[e*W +: W] = 32'(10 + e);
        v1 = 1'b1;
        wait_accept(port);
        v1 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("skew_lane2_c%0d", c + 1), sys_a[2*W +: W], lane2_exp[c]);
        end
        wait_resp(lat);
        chk("skew_latency", lat + 6, 14);
        tick();

        // Consumer back-pressure with a new request waiting.
        rand_ops();
        rsp_ready = 1'b0; v0 = 1'b1;
        wait_accept(port);
        rand_ops();
        wait_resp(lat);
        chk("hold_latency", lat, 14);
        repeat (5) tick();
        rsp_ready = 1'b1;
        wait_accept(port);
        v0 = 1'b0;
        wait_resp(lat);
        tick();

        // Stall for 4 cycles mid-FEED.
        rand_ops();
        v1 = 1'b1;
        wait_accept(port);
        v1 = 1'b0;
        tick();
        en = 1'b0;
        repeat (4) tick();
        en = 1'b1;
        wait_resp(lat);
        chk("stall_latency", lat + 5, 18);
        tick();

        // Reset in cycle 5 aborts the job; then a normal job.
        rand_ops();
        v0 = 1'b1;
        wait_accept(port);
        v0 = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_sys_A", sys_a, 0);
        chk("rst_sys_en", sys_en, 0);
        repeat (20) tick();
        rand_ops();
        v0 = 1'b1;
        wait_accept(port);
        v0 = 1'b0;
        wait_resp(lat);
        chk("post_rst_latency", lat, 14);
        tick();

        // Randomised traffic.
        for (int c = 0; c < 800; c++) begin
            v0        = ($urandom % 3) == 0;
            v1        = ($urandom % 3) == 0;
            en        = ($urandom % 8) != 0;
            rsp_ready = ($urandom % 3) != 0;
            rst       = ($urandom % 400) == 0;
            rand_ops();
            tick();
        end
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0; en = 1'b1; rsp_ready = 1'b1;
        repeat (40) tick();
        chk("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
